// File: rtl/riscv_mc_controller.sv
// Multicycle RV32I control unit: sequences each instruction through FSM states and
// drives datapath selects/strobes, with optional wait states on every memory access.
module riscv_mc_controller #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    state_t             out_state;
    logic [CNT_W-1:0]   wcnt_q;
    logic [CNT_W-1:0]   wcnt_d;
    logic               wait_done;
    logic [2:0]         funct_alu;

    assign wait_done = (wcnt_q == CNT_W'(WAIT_CYCLES));
    assign state     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Memory states hold until the wait counter reaches WAIT_CYCLES; every other state is one cycle.
    always_comb begin
        state_d = FETCH;
        wcnt_d  = '0;
        case (state_q)
            FETCH: begin
                if (wait_done) begin
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                    wcnt_d  = wcnt_q + CNT_W'(1);
                end
            end
            DECODE: begin
                case (op)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011:             state_d = EXECR;
                    7'b0010011:             state_d = EXECI;
                    7'b1100011:             state_d = BRANCH;
                    7'b1101111:             state_d = JAL;
                    default:                state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (wait_done) begin
                    state_d = MEMWB;
                end else begin
                    state_d = MEMREAD;
                    wcnt_d  = wcnt_q + CNT_W'(1);
                end
            end
            MEMWB:   state_d = FETCH;
            MEMWRITE: begin
                if (wait_done) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEMWRITE;
                    wcnt_d  = wcnt_q + CNT_W'(1);
                end
            end
            EXECR:   state_d = ALUWB;
            EXECI:   state_d = ALUWB;
            ALUWB:   state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JAL:     state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Only R-type (op[5]=1) may select sub for funct3=000; addi always adds.
    always_comb begin
        case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? 3'b001 : 3'b000;
            3'b010:  funct_alu = 3'b101;
            3'b110:  funct_alu = 3'b011;
            3'b111:  funct_alu = 3'b010;
            default: funct_alu = 3'b000;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: imm_src = 2'b01;
            7'b1100011: imm_src = 2'b10;
            7'b1101111: imm_src = 2'b11;
            default:    imm_src = 2'b00;
        endcase
    end

    // During reset the selects show FETCH values and every strobe is held low.
    always_comb begin
        out_state   = reset ? FETCH : state_q;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        case (out_state)
            FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = wait_done;
                pc_write   = wait_done;
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = wait_done;
            end
            EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = funct_alu;
            end
            EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
            end
            ALUWB:    reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = 3'b001;
                pc_write    = ((funct3 == 3'b000) & zero) | ((funct3 == 3'b001) & ~zero);
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Scoreboard bench for riscv_mc_controller: three instances (WAIT_CYCLES 0, 2, 3) share
// instruction inputs; each test pushes expected per-cycle outputs and pops them per cycle.
module tb_riscv_mc_controller;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                           S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                           S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, irw, mw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst [3];
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;

    logic       pcw_o [3], adr_o [3], irw_o [3], mw_o [3], rw_o [3];
    logic [1:0] rs_o [3], sa_o [3], sb_o [3], imm_o [3];
    logic [2:0] alu_o [3];
    logic [3:0] st_o [3];

    int   checks = 0;
    int   errors = 0;
    vec_t sb_q [$];
    vec_t got, exp_v;

    always #5 clk = ~clk;

    riscv_mc_controller #(.WAIT_CYCLES(0), .CNT_W(4)) dut_w0 (
        .clk(clk), .reset(rst[0]), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pcw_o[0]), .adr_src(adr_o[0]), .ir_write(irw_o[0]), .mem_write(mw_o[0]),
        .reg_write(rw_o[0]), .result_src(rs_o[0]), .alu_src_a(sa_o[0]), .alu_src_b(sb_o[0]),
        .imm_src(imm_o[0]), .alu_control(alu_o[0]), .state(st_o[0]));

    riscv_mc_controller #(.WAIT_CYCLES(2), .CNT_W(4)) dut_w2 (
        .clk(clk), .reset(rst[1]), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pcw_o[1]), .adr_src(adr_o[1]), .ir_write(irw_o[1]), .mem_write(mw_o[1]),
        .reg_write(rw_o[1]), .result_src(rs_o[1]), .alu_src_a(sa_o[1]), .alu_src_b(sb_o[1]),
        .imm_src(imm_o[1]), .alu_control(alu_o[1]), .state(st_o[1]));

    riscv_mc_controller #(.WAIT_CYCLES(3), .CNT_W(4)) dut_w3 (
        .clk(clk), .reset(rst[2]), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pc_write(pcw_o[2]), .adr_src(adr_o[2]), .ir_write(irw_o[2]), .mem_write(mw_o[2]),
        .reg_write(rw_o[2]), .result_src(rs_o[2]), .alu_src_a(sa_o[2]), .alu_src_b(sb_o[2]),
        .imm_src(imm_o[2]), .alu_control(alu_o[2]), .state(st_o[2]));

    function automatic vec_t sample(input int i);
        vec_t v;
        v.st = st_o[i];  v.pcw = pcw_o[i]; v.adr = adr_o[i]; v.irw = irw_o[i];
        v.mw = mw_o[i];  v.rw = rw_o[i];   v.rs = rs_o[i];   v.sa = sa_o[i];
        v.sb = sb_o[i];  v.imm = imm_o[i]; v.alu = alu_o[i];
        return v;
    endfunction

    // Per-state output table; strobe marks the final cycle of a memory state.
    function automatic vec_t spec_vec(input logic [3:0] s, input logic strobe, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic br_pc);
        vec_t v;
        v = '0;
        v.st  = s;
        v.imm = imm;
        case (s)
            S_FETCH:    begin v.sb = 2'b10; v.rs = 2'b10; v.irw = strobe; v.pcw = strobe; end
            S_DECODE:   begin v.sa = 2'b01; v.sb = 2'b01; end
            S_MEMADR:   begin v.sa = 2'b10; v.sb = 2'b01; end
            S_MEMREAD:  v.adr = 1'b1;
            S_MEMWB:    begin v.rs = 2'b01; v.rw = 1'b1; end
            S_MEMWRITE: begin v.adr = 1'b1; v.mw = strobe; end
            S_EXECR:    begin v.sa = 2'b10; v.alu = alu; end
            S_EXECI:    begin v.sa = 2'b10; v.sb = 2'b01; v.alu = alu; end
            S_ALUWB:    v.rw = 1'b1;
            S_BRANCH:   begin v.sa = 2'b10; v.alu = 3'b001; v.pcw = br_pc; end
            S_JAL:      begin v.sa = 2'b01; v.sb = 2'b10; v.pcw = 1'b1; end
            default:    v = '0;
        endcase
        return v;
    endfunction

    task automatic do_reset(input int i);
        rst[i] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst[i] = 1'b0;
    endtask

    task automatic test_reset();
        vec_t rv;
        op = 7'b0100011;
        rst[0] = 1'b1;
        rv = spec_vec(S_FETCH, 1'b0, 2'b01, 3'b000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            got = sample(0);
            checks++;
            if (got !== rv) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", k, got, rv);
            end
        end
        @(negedge clk);
        rst[0] = 1'b0;
        #1;
        got = sample(0);
        rv = spec_vec(S_FETCH, 1'b1, 2'b01, 3'b000, 1'b0);
        checks++;
        if (got !== rv) begin
            errors++;
            $display("[TB] FAIL reset_first_fetch: got %h expected %h", got, rv);
        end
        @(negedge clk);
    endtask

    task automatic test_lw();
        do_reset(0);
        op = 7'b0000011;
        sb_q.push_back(spec_vec(S_FETCH,   1'b1, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE,  1'b0, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_MEMADR,  1'b0, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_MEMREAD, 1'b0, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_MEMWB,   1'b0, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_FETCH,   1'b1, 2'b00, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(0);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL lw_w0 cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait3();
        do_reset(2);
        op = 7'b0100011;
        for (int k = 0; k < 4; k++) sb_q.push_back(spec_vec(S_FETCH, k == 3, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_MEMADR, 1'b0, 2'b01, 3'b000, 1'b0));
        for (int k = 0; k < 4; k++) sb_q.push_back(spec_vec(S_MEMWRITE, k == 3, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_FETCH, 1'b0, 2'b01, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(2);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL sw_w3 cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_memwrite();
        vec_t rv;
        do_reset(1);
        op = 7'b0100011;
        for (int k = 0; k < 3; k++) sb_q.push_back(spec_vec(S_FETCH, k == 2, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_MEMADR, 1'b0, 2'b01, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(1);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL memwrite_reset_pre cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
        rst[1] = 1'b1;
        #1;
        got = sample(1);
        rv = spec_vec(S_FETCH, 1'b0, 2'b01, 3'b000, 1'b0);
        rv.st = S_MEMWRITE;
        checks++;
        if (got !== rv) begin
            errors++;
            $display("[TB] FAIL memwrite_reset_cycle: got %h expected %h", got, rv);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        for (int k = 0; k < 3; k++) sb_q.push_back(spec_vec(S_FETCH, k == 2, 2'b01, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b01, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(1);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL memwrite_reset_post cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [2:0] f3_t [5] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010};
        logic       z_t  [5] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b1};
        logic       pc_t [5] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
        for (int c = 0; c < 5; c++) begin
            do_reset(0);
            op = 7'b1100011;
            funct3 = f3_t[c];
            zero = z_t[c];
            sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b10, 3'b000, 1'b0));
            sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b10, 3'b000, 1'b0));
            sb_q.push_back(spec_vec(S_BRANCH, 1'b0, 2'b10, 3'b001, pc_t[c]));
            sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b10, 3'b000, 1'b0));
            for (int n = 0; sb_q.size() > 0; n++) begin
                #1;
                got = sample(0);
                exp_v = sb_q.pop_front();
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL branch case %0d cycle %0d: got %h expected %h", c, n, got, exp_v);
                end
                @(negedge clk);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_alu_decode();
        logic [6:0] op_t  [7] = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011,
                                  7'b0010011, 7'b0010011};
        logic [2:0] f3_t  [7] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b000, 3'b010};
        logic       f7_t  [7] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0};
        logic [2:0] alu_t [7] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000, 3'b101};
        logic [3:0] ex_t  [7] = '{S_EXECR, S_EXECR, S_EXECR, S_EXECR, S_EXECR, S_EXECI, S_EXECI};
        for (int c = 0; c < 7; c++) begin
            do_reset(0);
            op = op_t[c];
            funct3 = f3_t[c];
            funct7b5 = f7_t[c];
            sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b00, 3'b000, 1'b0));
            sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b00, 3'b000, 1'b0));
            sb_q.push_back(spec_vec(ex_t[c],  1'b0, 2'b00, alu_t[c], 1'b0));
            sb_q.push_back(spec_vec(S_ALUWB,  1'b0, 2'b00, 3'b000, 1'b0));
            sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b00, 3'b000, 1'b0));
            for (int n = 0; sb_q.size() > 0; n++) begin
                #1;
                got = sample(0);
                exp_v = sb_q.pop_front();
                checks++;
                if (got !== exp_v) begin
                    errors++;
                    $display("[TB] FAIL alu_decode case %0d cycle %0d: got %h expected %h", c, n, got, exp_v);
                end
                @(negedge clk);
            end
        end
        funct3 = 3'b000;
        funct7b5 = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset(0);
        op = 7'b0000000;
        sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b00, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b00, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(0);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL nop cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
        op = 7'b1101111;
        sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b11, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_DECODE, 1'b0, 2'b11, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_JAL,    1'b0, 2'b11, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_ALUWB,  1'b0, 2'b11, 3'b000, 1'b0));
        sb_q.push_back(spec_vec(S_FETCH,  1'b1, 2'b11, 3'b000, 1'b0));
        for (int n = 0; sb_q.size() > 0; n++) begin
            #1;
            got = sample(0);
            exp_v = sb_q.pop_front();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("[TB] FAIL jal cycle %0d: got %h expected %h", n, got, exp_v);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        rst[2] = 1'b1;
        @(negedge clk);
        test_reset();
        test_lw();
        test_sw_wait3();
        test_reset_mid_memwrite();
        test_branch();
        test_alu_decode();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
